// File: rtl/bp_be_pkg.sv
// Shared definitions for the BE front-end queue slice.
//
// Contents:
//   fe_queue_els_gp        default entry count of the FE queue
//   fe_queue_ptr_width()   pointer width for a given entry count (index bits + wrap bit)
//   bp_be_fe_queue_ptr_s   pointer layout {wrap, idx} at the default entry count
package bp_be_pkg;

  localparam int fe_queue_els_gp = 8;

  // Index bits plus one wrap bit, so full and empty remain distinguishable
  // when the indices are equal.
  function automatic int fe_queue_ptr_width(input int els);
    return $clog2(els) + 1;
  endfunction

  localparam int fe_queue_idx_width_gp = $clog2(fe_queue_els_gp);

  typedef struct packed {
    logic                             wrap;
    logic [fe_queue_idx_width_gp-1:0] idx;
  } bp_be_fe_queue_ptr_s;

endpackage

// File: rtl/bp_be_fe_queue_ptr_ctrl.sv
// Pointer control for the checkpointed FE queue.
//
// Holds the write, speculative-read and commit pointers, and resolves the
// clr > roll > yumi priority on the read pointer. deq is folded into the
// commit pointer first, so roll and clr both see the post-commit checkpoint.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   enq              message accepted this cycle (valid & ready)
//   yumi             presented message consumed
//   roll             rewind read pointer to checkpoint
//   clr              flush all entries
//   deq              retire the oldest read entry
//   widx, ridx       storage indices for write and read
//   empty            no unread entries
//   full             occupancy relative to the checkpoint equals els_p
//   ready            buffer can accept a message
module bp_be_fe_queue_ptr_ctrl
  import bp_be_pkg::*;
#(
  parameter  int els_p        = fe_queue_els_gp,
  localparam int ptr_width_lp = fe_queue_ptr_width(els_p),
  localparam int idx_width_lp = ptr_width_lp - 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enq,
  input  logic                    yumi,
  input  logic                    roll,
  input  logic                    clr,
  input  logic                    deq,
  output logic [idx_width_lp-1:0] widx,
  output logic [idx_width_lp-1:0] ridx,
  output logic                    empty,
  output logic                    full,
  output logic                    ready
);

  logic [ptr_width_lp-1:0] wptr_reg, rptr_reg, cptr_reg;
  logic [ptr_width_lp-1:0] wptr_next, rptr_next, cptr_next;
  // Holds ready low through reset and releases it on the first clock after.
  logic                    ready_en_reg;

  always_comb begin
    cptr_next = cptr_reg + ptr_width_lp'(deq);
    wptr_next = wptr_reg + ptr_width_lp'(enq);
    rptr_next = rptr_reg;
    if (clr) begin
      wptr_next = cptr_next;
      rptr_next = cptr_next;
    end else if (roll) begin
      rptr_next = cptr_next;
    end else if (yumi) begin
      rptr_next = rptr_reg + ptr_width_lp'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      cptr_reg     <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      wptr_reg     <= wptr_next;
      rptr_reg     <= rptr_next;
      cptr_reg     <= cptr_next;
      ready_en_reg <= 1'b1;
    end
  end

  // Full is measured from the checkpoint: read-but-uncommitted entries still
  // occupy storage because a roll may replay them.
  assign full  = (wptr_reg - cptr_reg) == ptr_width_lp'(els_p);
  assign empty = (rptr_reg == wptr_reg);
  assign ready = ready_en_reg & ~full;
  assign widx  = wptr_reg[idx_width_lp-1:0];
  assign ridx  = rptr_reg[idx_width_lp-1:0];

endmodule

// File: rtl/bp_be_fe_queue_ckpt.sv
// Checkpointed FE queue between the front-end fetch port and the BE issue
// scheduler. Messages stay in storage after the scheduler consumes them and
// are freed only on deq (commit), so a roll can replay from the oldest
// uncommitted entry.
//
// Configuration macro: BP_BE_FE_QUEUE_BYPASS_EN
//   defined   - an accepted message arriving while the buffer is empty is
//               presented in the same cycle (still written for replay);
//               suppressed in clr or roll cycles
//   undefined - 1-cycle latency, no combinational input-to-output path
//
// Ports:
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   fe_queue_data_i    message from the front end
//   fe_queue_v_i       front end offers a message
//   fe_queue_ready_o   buffer can accept a message
//   fe_queue_data_o    oldest unread message
//   fe_queue_v_o       unread message available
//   fe_queue_yumi_i    scheduler consumes the presented message
//   fe_queue_clr_i     flush everything
//   fe_queue_roll_i    rewind read pointer to the checkpoint
//   fe_queue_deq_i     commit the oldest read entry
//   empty_o            no unread entries
//   full_o             occupancy relative to the checkpoint equals els_p
module bp_be_fe_queue_ckpt
  import bp_be_pkg::*;
#(
  parameter  int els_p        = fe_queue_els_gp,
  parameter  int data_width_p = 128,
  localparam int ptr_width_lp = fe_queue_ptr_width(els_p),
  localparam int idx_width_lp = ptr_width_lp - 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [data_width_p-1:0] fe_queue_data_i,
  input  logic                    fe_queue_v_i,
  output logic                    fe_queue_ready_o,
  output logic [data_width_p-1:0] fe_queue_data_o,
  output logic                    fe_queue_v_o,
  input  logic                    fe_queue_yumi_i,
  input  logic                    fe_queue_clr_i,
  input  logic                    fe_queue_roll_i,
  input  logic                    fe_queue_deq_i,
  output logic                    empty_o,
  output logic                    full_o
);

  logic                    enq;
  logic                    wr_en;
  logic [idx_width_lp-1:0] widx;
  logic [idx_width_lp-1:0] ridx;
  logic [data_width_p-1:0] mem_reg [els_p];

  // Ready depends only on registered state, so this has no loop through
  // the pointer logic.
  assign enq   = fe_queue_v_i & fe_queue_ready_o;
  // A clr discards any same-cycle enqueue; the pointer block drops it too.
  assign wr_en = enq & ~fe_queue_clr_i;

  bp_be_fe_queue_ptr_ctrl #(
    .els_p (els_p)
  ) ptr_ctrl (
    .clk     (clk_i),
    .reset_n (reset_n_i),
    .enq     (enq),
    .yumi    (fe_queue_yumi_i),
    .roll    (fe_queue_roll_i),
    .clr     (fe_queue_clr_i),
    .deq     (fe_queue_deq_i),
    .widx    (widx),
    .ridx    (ridx),
    .empty   (empty_o),
    .full    (full_o),
    .ready   (fe_queue_ready_o)
  );

  // Storage is intentionally not reset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_reg[widx] <= fe_queue_data_i;
    end
  end

`ifdef BP_BE_FE_QUEUE_BYPASS_EN
  logic bypass;

  assign bypass          = empty_o & enq & ~fe_queue_clr_i & ~fe_queue_roll_i;
  assign fe_queue_v_o    = ~empty_o | bypass;
  assign fe_queue_data_o = bypass ? fe_queue_data_i : mem_reg[ridx];
`else
  assign fe_queue_v_o    = ~empty_o;
  assign fe_queue_data_o = mem_reg[ridx];
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_ckpt.sv
// Scoreboard bench for bp_be_fe_queue_ckpt. The reference model keeps the
// uncommitted entries in a queue plus a count of how many have been read;
// each cycle the stimulus pushes the expected outputs and a monitor pops and
// compares them shortly after the falling edge.
module tb_bp_be_fe_queue_ckpt;

  localparam int els_lp = 8;
  localparam int dw_lp  = 128;

  logic             clk_i = 1'b0;
  logic             reset_n_i = 1'b0;
  logic [dw_lp-1:0] fe_queue_data_i = '0;
  logic             fe_queue_v_i = 1'b0;
  logic             fe_queue_ready_o;
  logic [dw_lp-1:0] fe_queue_data_o;
  logic             fe_queue_v_o;
  logic             fe_queue_yumi_i = 1'b0;
  logic             fe_queue_clr_i = 1'b0;
  logic             fe_queue_roll_i = 1'b0;
  logic             fe_queue_deq_i = 1'b0;
  logic             empty_o;
  logic             full_o;

  always #5 clk_i = ~clk_i;

  bp_be_fe_queue_ckpt #(
    .els_p        (els_lp),
    .data_width_p (dw_lp)
  ) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .fe_queue_data_i  (fe_queue_data_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .fe_queue_data_o  (fe_queue_data_o),
    .fe_queue_v_o     (fe_queue_v_o),
    .fe_queue_yumi_i  (fe_queue_yumi_i),
    .fe_queue_clr_i   (fe_queue_clr_i),
    .fe_queue_roll_i  (fe_queue_roll_i),
    .fe_queue_deq_i   (fe_queue_deq_i),
    .empty_o          (empty_o),
    .full_o           (full_o)
  );

  typedef struct packed {
    logic             v;
    logic [dw_lp-1:0] data;
    logic             empty;
    logic             full;
    logic             ready;
  } exp_s;

  exp_s  exp_q[$];
  string tag_q[$];

  // Reference model: uncommitted entries oldest first, and how many of them
  // the scheduler has already consumed.
  logic [dw_lp-1:0] q_m[$];
  int               rd_m = 0;
  bit               oor_m = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  bit running = 1'b0;

  function automatic bit m_empty();
    return rd_m == q_m.size();
  endfunction

  function automatic bit m_full();
    return q_m.size() == els_lp;
  endfunction

  function automatic bit m_ready();
    return oor_m && !m_full();
  endfunction

  function automatic bit m_bypass(input bit v, input bit clr, input bit roll);
    bit en;
    en = 1'b0;
`ifdef BP_BE_FE_QUEUE_BYPASS_EN
    en = 1'b1;
`endif
    return en && m_empty() && v && m_ready() && !clr && !roll;
  endfunction

  function automatic bit m_valid(input bit v, input bit clr, input bit roll);
    return !m_empty() || m_bypass(v, clr, roll);
  endfunction

  task automatic cycle(input bit rst_n, input bit v, input logic [dw_lp-1:0] d,
                       input bit yumi, input bit clr, input bit roll, input bit deq,
                       input string tag);
    exp_s e;
    bit   enq;
    @(negedge clk_i);
    reset_n_i       = rst_n;
    fe_queue_v_i    = v;
    fe_queue_data_i = d;
    fe_queue_yumi_i = yumi;
    fe_queue_clr_i  = clr;
    fe_queue_roll_i = roll;
    fe_queue_deq_i  = deq;
    if (!rst_n) begin
      q_m.delete();
      rd_m  = 0;
      oor_m = 1'b0;
    end
    e.empty = m_empty();
    e.full  = m_full();
    e.ready = m_ready();
    e.v     = !e.empty;
    e.data  = e.v ? q_m[rd_m] : '0;
    if (rst_n && m_bypass(v, clr, roll)) begin
      e.v    = 1'b1;
      e.data = d;
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    enq = v && e.ready && !clr;
    @(posedge clk_i);
    if (rst_n) begin
      if (deq) begin
        void'(q_m.pop_front());
        rd_m--;
      end
      if (clr) begin
        q_m.delete();
        rd_m = 0;
      end else begin
        if (roll) rd_m = 0;
        else if (yumi) rd_m++;
        if (enq) q_m.push_back(d);
      end
      oor_m = 1'b1;
    end
  endtask

  task automatic idle(input string tag);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // Monitor: compares one expectation per cycle, after inputs have settled.
  initial begin
    forever begin
      exp_s  e;
      string t;
      @(negedge clk_i);
      #1;
      if (exp_q.size() == 0) begin
        if (running) begin
          miscompares++;
          $display("FAIL scoreboard: no expectation queued at %0t", $time);
        end
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        vectors++;
        if (fe_queue_v_o !== e.v) begin
          miscompares++;
          $display("FAIL %s v_o: got %0b want %0b", t, fe_queue_v_o, e.v);
        end
        if (e.v && fe_queue_data_o !== e.data) begin
          miscompares++;
          $display("FAIL %s data_o: got %h want %h", t, fe_queue_data_o, e.data);
        end
        if (empty_o !== e.empty) begin
          miscompares++;
          $display("FAIL %s empty_o: got %0b want %0b", t, empty_o, e.empty);
        end
        if (full_o !== e.full) begin
          miscompares++;
          $display("FAIL %s full_o: got %0b want %0b", t, full_o, e.full);
        end
        if (fe_queue_ready_o !== e.ready) begin
          miscompares++;
          $display("FAIL %s ready_o: got %0b want %0b", t, fe_queue_ready_o, e.ready);
        end
        $display("%0t %s v=%0b data=%h empty=%0b full=%0b ready=%0b",
                 $time, t, fe_queue_v_o, fe_queue_data_o, empty_o, full_o, fe_queue_ready_o);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    running = 1'b1;

    // Reset and release
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    cycle(1'b0, 1'b1, 128'h1, 1'b0, 1'b0, 1'b0, 1'b0, "reset_enq_ignored");
    idle("release");
    idle("ready_up");

    // Fill to full, try one more, drain by yumi then commit
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 128'(i), 1'b0, 1'b0, 1'b0, 1'b0, "fill");
    cycle(1'b1, 1'b1, 128'hdead, 1'b0, 1'b0, 1'b0, 1'b0, "enq_when_full");
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, "drain_yumi");
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "deq_still_full");
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "drain_deq");
    idle("drained");

    // Roll replay
    cycle(1'b1, 1'b1, 128'hA, 1'b0, 1'b0, 1'b0, 1'b0, "enq_A");
    cycle(1'b1, 1'b1, 128'hB, 1'b0, 1'b0, 1'b0, 1'b0, "enq_B");
    cycle(1'b1, 1'b1, 128'hC, 1'b0, 1'b0, 1'b0, 1'b0, "enq_C");
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, "yumi_A");
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, "yumi_B");
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "deq_A");
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, "roll_with_yumi");
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, "replay_B");
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, "replay_C");
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "deq_B");
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "deq_C");

    // Clr with concurrent enqueue
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 128'(16 + i), 1'b0, 1'b0, 1'b0, 1'b0, "enq_pre_clr");
    cycle(1'b1, 1'b1, 128'hD, 1'b0, 1'b1, 1'b0, 1'b0, "clr_enq_D");
    idle("after_clr");
    cycle(1'b1, 1'b1, 128'hE, 1'b0, 1'b0, 1'b0, 1'b0, "enq_E");
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, "yumi_E");
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "deq_E");

    // Wrap-around with occupancy at most one
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 128'(256 + i), 1'b0, 1'b0, 1'b0, 1'b0, "wrap_enq");
      cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, "wrap_yumi");
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "wrap_deq");
    end

    // Roll together with deq rewinds to the post-commit checkpoint
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 128'(512 + i), 1'b0, 1'b0, 1'b0, 1'b0, "rd_enq");
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, "rd_yumi");
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "rd_deq");
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, "roll_and_deq");
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, "rd_replay_3");
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, "rd_cleanup_clr");

    // Asynchronous reset with entries pending, then enqueue into empty buffer
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 128'(768 + i), 1'b0, 1'b0, 1'b0, 1'b0, "pre_reset_enq");
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, "async_reset");
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, "async_reset_hold");
    idle("reset_release");
    cycle(1'b1, 1'b1, 128'hF, 1'b0, 1'b0, 1'b0, 1'b0, "enq_F");
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, "yumi_F");
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "deq_F");

    // Random legal traffic
    for (int n = 0; n < 400; n++) begin
      bit               v, clr, roll, deq, yumi, rst_n;
      logic [dw_lp-1:0] d;
      rst_n = ($urandom_range(0, 199) != 0);
      v     = ($urandom_range(0, 99) < 60);
      clr   = ($urandom_range(0, 99) < 3);
      roll  = !clr && ($urandom_range(0, 99) < 6);
      deq   = (rd_m > 0) && ($urandom_range(0, 99) < 35);
      yumi  = m_valid(v, clr, roll) && ($urandom_range(0, 99) < 55);
      d     = {$urandom, $urandom, $urandom, $urandom};
      cycle(rst_n, v, d, yumi, clr, roll, deq, "random");
    end

    idle("final");
    running = 1'b0;
    repeat (2) @(negedge clk_i);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: %0d expectations left unchecked", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
